// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
// Definitions shared by the UART frame sequencer and its byte selector:
//   - frame_state_t : 2-bit controller state encoding
//   - DEFAULT_HDR0/1: default frame header bytes
//   - clog2()       : width of the byte index for a frame of a given length
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } frame_state_t;

  localparam logic [7:0] DEFAULT_HDR0 = 8'hAA;
  localparam logic [7:0] DEFAULT_HDR1 = 8'h55;

  // Smallest width able to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/uart_frame_mux.sv
// uart_frame_mux
// Combinational byte selector: maps a frame byte index to the byte that
// belongs at that position in the packet.
//   i_idx     : byte index within the frame (0 .. PAYLOAD_BYTES+4)
//   i_seq     : sequence number for this frame
//   i_chk     : running checksum, sent as the final byte
//   i_payload : latched payload, most significant byte sent first
//   o_byte    : selected byte
import uart_frame_pkg::*;

module uart_frame_mux #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         IDX_W         = clog2(PAYLOAD_BYTES + 5),
  parameter logic [7:0] HDR0          = DEFAULT_HDR0,
  parameter logic [7:0] HDR1          = DEFAULT_HDR1
) (
  input  logic [IDX_W-1:0]           i_idx,
  input  logic [7:0]                 i_seq,
  input  logic [7:0]                 i_chk,
  input  logic [PAYLOAD_BYTES*8-1:0] i_payload,
  output logic [7:0]                 o_byte
);

  // Layout: HDR0, HDR1, SEQ, LEN, payload (MSB first), CHK.
  // The checksum is the default so the final index needs no explicit arm.
  always_comb begin
    o_byte = i_chk;
    if (i_idx == IDX_W'(0)) begin
      o_byte = HDR0;
    end else if (i_idx == IDX_W'(1)) begin
      o_byte = HDR1;
    end else if (i_idx == IDX_W'(2)) begin
      o_byte = i_seq;
    end else if (i_idx == IDX_W'(3)) begin
      o_byte = 8'(PAYLOAD_BYTES);
    end else begin
      for (int b = 0; b < PAYLOAD_BYTES; b++) begin
        if (i_idx == IDX_W'(b + 4)) o_byte = i_payload[(PAYLOAD_BYTES-1-b)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx_ctrl.sv
// uart_frame_tx_ctrl
// Frame sequencer for the UART transmit path. A single-cycle frame_req
// latches the payload and the block then emits HDR0, HDR1, SEQ, LEN,
// payload bytes (MSB first) and CHK, one byte per valid/ready handshake,
// with one idle cycle between bytes.
//   clk_50m       : system clock
//   rst           : synchronous active-high reset
//   frame_req     : single-cycle request to send a frame
//   payload       : payload, sampled only when a request is accepted
//   frame_busy    : a frame is in progress (including the done cycle)
//   frame_done    : one-cycle pulse after the last byte is accepted
//   req_dropped   : one-cycle pulse for a request arriving while busy
//   tx_data_valid : byte valid towards the UART transmitter
//   tx_data       : byte towards the UART transmitter
//   tx_data_ready : byte ready from the UART transmitter
import uart_frame_pkg::*;

module uart_frame_tx_ctrl #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] HDR0          = DEFAULT_HDR0,
  parameter logic [7:0] HDR1          = DEFAULT_HDR1
) (
  input  logic                       clk_50m,
  input  logic                       rst,
  input  logic                       frame_req,
  input  logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic                       req_dropped,
  output logic                       tx_data_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_data_ready
);

  localparam int NUM_BYTES = PAYLOAD_BYTES + 5;
  localparam int IDX_W     = clog2(NUM_BYTES);

  // SEQ, LEN and the payload feed the checksum; the headers do not.
  localparam logic [IDX_W-1:0] IDX_FIRST_SUM = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_LAST_SUM  = IDX_W'(PAYLOAD_BYTES + 3);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_BYTES - 1);

  frame_state_t               r_state;
  frame_state_t               w_nextState;
  logic [PAYLOAD_BYTES*8-1:0] r_payload;
  logic [IDX_W-1:0]           r_idx;
  logic [7:0]                 r_acc;
  logic [7:0]                 r_seq;
  logic                       r_reqDropped;
  logic                       w_accept;
  logic [7:0]                 w_byte;

  assign w_accept = (r_state == S_SEND) && tx_data_ready;

  uart_frame_mux #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .IDX_W         (IDX_W),
    .HDR0          (HDR0),
    .HDR1          (HDR1)
  ) u_mux (
    .i_idx     (r_idx),
    .i_seq     (r_seq),
    .i_chk     (r_acc),
    .i_payload (r_payload),
    .o_byte    (w_byte)
  );

  // State register.
  always_ff @(posedge clk_50m) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic. The GAP state gives the transmitter the one idle
  // cycle it needs after dropping ready on acceptance.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (frame_req) w_nextState = S_SEND;
      S_SEND:  if (w_accept) w_nextState = (r_idx == IDX_LAST) ? S_DONE : S_GAP;
      S_GAP:   w_nextState = S_SEND;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: payload latch, byte index, checksum accumulator, sequence
  // counter and the dropped-request pulse. The checksum is built from the
  // bytes actually handed over, so CHK reflects exactly what was sent.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_payload    <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_seq        <= '0;
      r_reqDropped <= 1'b0;
    end else begin
      r_reqDropped <= frame_req && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (frame_req) begin
            r_payload <= payload;
            r_idx     <= '0;
            r_acc     <= '0;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_idx >= IDX_FIRST_SUM && r_idx <= IDX_LAST_SUM) r_acc <= r_acc + w_byte;
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE:  r_seq <= r_seq + 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state; tx_data is forced to zero outside SEND
  // so it reads 8'h00 out of reset.
  always_comb begin
    tx_data_valid = (r_state == S_SEND);
    tx_data       = (r_state == S_SEND) ? w_byte : 8'h00;
    frame_busy    = (r_state != S_IDLE);
    frame_done    = (r_state == S_DONE);
  end

  assign req_dropped = r_reqDropped;

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// tb_uart_frame_tx_ctrl
// Directed bench for the UART frame sequencer: reset values, basic frames
// with hand-computed checksums, transmitter stalls, dropped requests, a
// mid-frame reset and 257 back-to-back frames across the SEQ wrap.
module tb_uart_frame_tx_ctrl;

  localparam int BUDGET = 3000;

  logic        clk_50m;
  logic        rst;
  logic        frame_req;
  logic [31:0] payload;
  logic        frame_busy;
  logic        frame_done;
  logic        req_dropped;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_data_ready;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rxQ[$];

  uart_frame_tx_ctrl #(
    .PAYLOAD_BYTES (4),
    .HDR0          (8'hAA),
    .HDR1          (8'h55)
  ) dut (
    .clk_50m       (clk_50m),
    .rst           (rst),
    .frame_req     (frame_req),
    .payload       (payload),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .req_dropped   (req_dropped),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  // Reference frame byte for the back-to-back run.
  function automatic logic [7:0] model_byte(input logic [7:0] seq, input logic [31:0] pay, input int i);
    logic [7:0] sum;
    sum = seq + 8'd4 + pay[31:24] + pay[23:16] + pay[15:8] + pay[7:0];
    if (i == 0) return 8'hAA;
    if (i == 1) return 8'h55;
    if (i == 2) return seq;
    if (i == 3) return 8'd4;
    if (i >= 4 && i <= 7) return pay[(7-i)*8 +: 8];
    return sum;
  endfunction

  // Sends one frame while acting as the UART transmitter: after every
  // accepted byte (and before the first) ready is held low for 'stall'
  // cycles. Accepted bytes are collected in rxQ. Optionally pulses
  // frame_req during byte number dropAt, or in the frame_done cycle.
  task automatic run_frame(input logic [31:0] pay, input int stall, input int dropAt, input bit dropInDone);
    int         stallCnt;
    int         dropCnt;
    int         cyc;
    bit         gapExpected;
    bit         heldValid;
    bit         dropIssued;
    bit         finished;
    logic [7:0] held;
    rxQ.delete();
    stallCnt    = stall;
    dropCnt     = 0;
    cyc         = 0;
    gapExpected = 0;
    heldValid   = 0;
    dropIssued  = 0;
    finished    = 0;
    held        = 8'h00;
    payload     = pay;
    frame_req   = 1'b1;
    step();
    frame_req = 1'b0;
    checks++;
    if (tx_data_valid !== 1'b1 || frame_busy !== 1'b1 || tx_data !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL first_byte: valid=%b busy=%b data=%h, required valid=1 busy=1 data=aa", tx_data_valid, frame_busy, tx_data);
    end
    while (!finished && cyc < BUDGET) begin
      if (stallCnt > 0) begin
        tx_data_ready = 1'b0;
        stallCnt--;
      end else begin
        tx_data_ready = 1'b1;
      end
      if (req_dropped === 1'b1) dropCnt++;
      if (gapExpected) begin
        checks++;
        if (tx_data_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL gap_cycle: valid=%b, required 0", tx_data_valid);
        end
        gapExpected = 0;
      end
      if (tx_data_valid === 1'b1) begin
        if (heldValid) begin
          checks++;
          if (tx_data !== held) begin
            errors++;
            $display("[TB] FAIL stall_hold: data=%h, required %h", tx_data, held);
          end
        end
        if (dropAt > 0 && rxQ.size() == dropAt - 1 && !dropIssued) begin
          frame_req  = 1'b1;
          payload    = ~pay;
          dropIssued = 1;
        end
        if (tx_data_ready) begin
          rxQ.push_back(tx_data);
          heldValid   = 0;
          gapExpected = 1;
          stallCnt    = stall;
        end else begin
          held      = tx_data;
          heldValid = 1;
        end
      end
      if (frame_done === 1'b1) begin
        finished = 1;
        if (dropInDone) frame_req = 1'b1;
      end
      step();
      frame_req = 1'b0;
      payload   = pay;
      cyc++;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout: no frame_done within %0d cycles, %0d bytes seen", BUDGET, rxQ.size());
    end else begin
      checks++;
      if (frame_done !== 1'b0 || frame_busy !== 1'b0 || tx_data_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL frame_end: done=%b busy=%b valid=%b, required all 0", frame_done, frame_busy, tx_data_valid);
      end
      checks++;
      if (dropCnt != ((dropAt > 0) ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL drop_count: %0d pulses, required %0d", dropCnt, (dropAt > 0) ? 1 : 0);
      end
      checks++;
      if (req_dropped !== dropInDone) begin
        errors++;
        $display("[TB] FAIL drop_in_done: req_dropped=%b, required %b", req_dropped, dropInDone);
      end
    end
    tx_data_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    frame_req     = 1'b0;
    payload       = 32'h0;
    tx_data_ready = 1'b1;
    step();
    step();
    checks++;
    if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || frame_busy !== 1'b0 ||
        frame_done !== 1'b0 || req_dropped !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: valid=%b data=%h busy=%b done=%b dropped=%b, required 0 00 0 0 0",
               tx_data_valid, tx_data, frame_busy, frame_done, req_dropped);
    end
    rst = 1'b0;
    step();
    checks++;
    if (tx_data_valid !== 1'b0 || frame_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: valid=%b busy=%b, required 0 0", tx_data_valid, frame_busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] expBytes[9] = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC2};
    run_frame(32'h1234ABCD, 0, 0, 0);
    checks++;
    if (rxQ.size() != 9) begin
      errors++;
      $display("[TB] FAIL basic_len: %0d bytes, required 9", rxQ.size());
    end
    for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== expBytes[i]) begin
        errors++;
        $display("[TB] FAIL basic_byte%0d: got %h, required %h", i, rxQ[i], expBytes[i]);
      end
    end
  endtask

  task automatic test_repeat();
    logic [7:0] expBytes[9] = '{8'hAA, 8'h55, 8'h01, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC3};
    run_frame(32'h1234ABCD, 0, 0, 0);
    checks++;
    if (rxQ.size() != 9) begin
      errors++;
      $display("[TB] FAIL repeat_len: %0d bytes, required 9", rxQ.size());
    end
    for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== expBytes[i]) begin
        errors++;
        $display("[TB] FAIL repeat_byte%0d: got %h, required %h", i, rxQ[i], expBytes[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] expBytes[9] = '{8'hAA, 8'h55, 8'h02, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC4};
    run_frame(32'h1234ABCD, 100, 0, 0);
    checks++;
    if (rxQ.size() != 9) begin
      errors++;
      $display("[TB] FAIL stall_len: %0d bytes, required 9", rxQ.size());
    end
    for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== expBytes[i]) begin
        errors++;
        $display("[TB] FAIL stall_byte%0d: got %h, required %h", i, rxQ[i], expBytes[i]);
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] expBytes[9] = '{8'hAA, 8'h55, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC5};
    run_frame(32'h1234ABCD, 0, 4, 0);
    checks++;
    if (rxQ.size() != 9) begin
      errors++;
      $display("[TB] FAIL drop_len: %0d bytes, required 9", rxQ.size());
    end
    for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== expBytes[i]) begin
        errors++;
        $display("[TB] FAIL drop_byte%0d: got %h, required %h", i, rxQ[i], expBytes[i]);
      end
    end
  endtask

  task automatic test_drop_in_done();
    logic [7:0] expBytes[9] = '{8'hAA, 8'h55, 8'h04, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC6};
    run_frame(32'h1234ABCD, 0, 0, 1);
    checks++;
    if (rxQ.size() != 9) begin
      errors++;
      $display("[TB] FAIL done_drop_len: %0d bytes, required 9", rxQ.size());
    end
    for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== expBytes[i]) begin
        errors++;
        $display("[TB] FAIL done_drop_byte%0d: got %h, required %h", i, rxQ[i], expBytes[i]);
      end
    end
    step();
    checks++;
    if (tx_data_valid !== 1'b0 || frame_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_drop_idle: valid=%b busy=%b, required 0 0", tx_data_valid, frame_busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] expBytes[9] = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC2};
    bit found;
    found         = 0;
    tx_data_ready = 1'b1;
    payload       = 32'h1234ABCD;
    frame_req     = 1'b1;
    step();
    frame_req = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (tx_data_valid === 1'b1 && tx_data === 8'h34) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL mid_reset_find: byte 34 never presented, required within 40 cycles");
    end else begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (tx_data_valid !== 1'b0 || frame_busy !== 1'b0 || frame_done !== 1'b0 || tx_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL mid_reset_outputs: valid=%b busy=%b done=%b data=%h, required 0 0 0 00",
                 tx_data_valid, frame_busy, frame_done, tx_data);
      end
      run_frame(32'h1234ABCD, 0, 0, 0);
      checks++;
      if (rxQ.size() != 9) begin
        errors++;
        $display("[TB] FAIL mid_reset_len: %0d bytes, required 9", rxQ.size());
      end
      for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
        checks++;
        if (rxQ[i] !== expBytes[i]) begin
          errors++;
          $display("[TB] FAIL mid_reset_byte%0d: got %h, required %h", i, rxQ[i], expBytes[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pay;
    logic [7:0]  seq;
    logic [7:0]  expByte;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      pay = 32'(k) * 32'h9E3779B1;
      seq = 8'(k - 1);
      run_frame(pay, 0, 0, 0);
      checks++;
      if (rxQ.size() != 9) begin
        errors++;
        $display("[TB] FAIL b2b_len frame %0d: %0d bytes, required 9", k, rxQ.size());
      end
      for (int i = 0; i < 9 && i < rxQ.size(); i++) begin
        expByte = model_byte(seq, pay, i);
        checks++;
        if (rxQ[i] !== expByte) begin
          errors++;
          $display("[TB] FAIL b2b frame %0d byte%0d: got %h, required %h", k, i, rxQ[i], expByte);
        end
      end
      if (k == 256 && rxQ.size() > 2) begin
        checks++;
        if (rxQ[2] !== 8'hFF) begin
          errors++;
          $display("[TB] FAIL seq_frame256: got %h, required ff", rxQ[2]);
        end
      end
      if (k == 257 && rxQ.size() > 2) begin
        checks++;
        if (rxQ[2] !== 8'h00) begin
          errors++;
          $display("[TB] FAIL seq_frame257: got %h, required 00", rxQ[2]);
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    frame_req     = 1'b0;
    payload       = 32'h0;
    tx_data_ready = 1'b1;
    test_reset();
    test_basic();
    test_repeat();
    test_stall();
    test_drop();
    test_drop_in_done();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
